// File: rtl/byte_memory_ctrl.sv
// -----------------------------------------------------------------------------
// byte_memory_ctrl
//   Byte-addressable, big-endian data memory behind a valid/ready request port
//   with a fixed access latency. Supports byte/half/word loads and stores with
//   sign or zero extension on loads. Misaligned, out-of-range and illegal-size
//   accesses complete with resp_err=1, resp_rdata=0 and no memory write.
//
// Handshake: a request is accepted on a rising edge where req_valid=1 and
//   req_ready=1 (req_ready is only high in IDLE). Request inputs are captured at
//   that edge and may change freely afterwards. resp_valid is a one-cycle pulse
//   qualifying resp_err and resp_rdata; there is no back-pressure on the
//   response side.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset (memory contents are kept)
//   req_valid    request present
//   req_ready    block can accept a request
//   req_write    1 = store, 0 = load
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned loads: 1 = zero-extend, 0 = sign-extend
//   req_addr     byte address
//   req_wdata    store data, bytes taken from the least-significant end
//   resp_valid   one-cycle response pulse
//   resp_err     error flag, qualified by resp_valid
//   resp_rdata   load result, qualified by resp_valid
//   o_dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 RESP)
// -----------------------------------------------------------------------------
module byte_memory_ctrl #(
    parameter int    DEPTH     = 64,
    parameter int    ADDR_W    = 32,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        o_dbg_state
);

    localparam int              IDX_W       = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LP_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      LP_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;

    // Latched request
    logic              r_write;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    // Memory array; never cleared by reset.
    logic [7:0]        r_mem [DEPTH];

    // With LATENCY==1 the commit edge is the accepting edge itself, so the
    // access is evaluated on the live request inputs; otherwise on the latched
    // copy.
    logic              w_accept;
    logic              w_commit;
    logic              w_sel_write;
    logic              w_sel_unsigned;
    logic [1:0]        w_sel_size;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [ADDR_W:0]   w_last_off;
    logic [ADDR_W:0]   w_end_addr;
    logic              w_err;
    logic [IDX_W-1:0]  w_idx0, w_idx1, w_idx2, w_idx3;
    logic [7:0]        w_b0, w_b1, w_b2, w_b3;
    logic              w_fill;
    logic [31:0]       w_load;
    logic [31:0]       w_rdata;

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_commit = (w_accept && (LATENCY == 1)) ||
                      ((r_state == ST_BUSY) && (r_cnt == 4'd1));

    always_comb begin
        w_sel_write    = r_write;
        w_sel_unsigned = r_unsigned;
        w_sel_size     = r_size;
        w_sel_addr     = r_addr;
        w_sel_wdata    = r_wdata;
        if (r_state == ST_IDLE) begin
            w_sel_write    = req_write;
            w_sel_unsigned = req_unsigned;
            w_sel_size     = req_size;
            w_sel_addr     = req_addr;
            w_sel_wdata    = req_wdata;
        end
    end

    // Range check at ADDR_W+1 bits so an access at the top of the address
    // space cannot wrap around to a small, apparently legal address.
    always_comb begin
        w_last_off = '0;
        case (w_sel_size)
            2'b00:   w_last_off = (ADDR_W+1)'(0);
            2'b01:   w_last_off = (ADDR_W+1)'(1);
            default: w_last_off = (ADDR_W+1)'(3);
        endcase
    end

    assign w_end_addr = {1'b0, w_sel_addr} + w_last_off;

    assign w_err = (w_sel_size == 2'b11) ||
                   ((w_sel_size == 2'b01) && w_sel_addr[0]) ||
                   ((w_sel_size == 2'b10) && (w_sel_addr[1:0] != 2'b00)) ||
                   (w_end_addr >= LP_DEPTH);

    assign w_idx0 = w_sel_addr[IDX_W-1:0];
    assign w_idx1 = w_idx0 + IDX_W'(1);
    assign w_idx2 = w_idx0 + IDX_W'(2);
    assign w_idx3 = w_idx0 + IDX_W'(3);

    assign w_b0 = r_mem[w_idx0];
    assign w_b1 = r_mem[w_idx1];
    assign w_b2 = r_mem[w_idx2];
    assign w_b3 = r_mem[w_idx3];

    // Big-endian assembly: the lowest address is the most significant byte.
    always_comb begin
        w_fill = 1'b0;
        w_load = '0;
        case (w_sel_size)
            2'b00: begin
                w_fill = ~w_sel_unsigned & w_b0[7];
                w_load = {{24{w_fill}}, w_b0};
            end
            2'b01: begin
                w_fill = ~w_sel_unsigned & w_b0[7];
                w_load = {{16{w_fill}}, w_b0, w_b1};
            end
            default: w_load = {w_b0, w_b1, w_b2, w_b3};
        endcase
    end

    assign w_rdata = (w_err || w_sel_write) ? 32'd0 : w_load;

    // Memory write port; gated by rst_n so a reset on the commit edge aborts
    // the store.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && w_sel_write && !w_err) begin
            case (w_sel_size)
                2'b00: r_mem[w_idx0] <= w_sel_wdata[7:0];
                2'b01: begin
                    r_mem[w_idx0] <= w_sel_wdata[15:8];
                    r_mem[w_idx1] <= w_sel_wdata[7:0];
                end
                2'b10: begin
                    r_mem[w_idx0] <= w_sel_wdata[31:24];
                    r_mem[w_idx1] <= w_sel_wdata[23:16];
                    r_mem[w_idx2] <= w_sel_wdata[15:8];
                    r_mem[w_idx3] <= w_sel_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    // Control FSM with registered outputs. The counter is loaded with
    // LATENCY-1 and RESP is entered on the edge that would take it to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_write      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_unsigned  <= req_unsigned;
                        r_size      <= req_size;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= LP_CNT_INIT;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_err;
                            r_resp_rdata <= w_rdata;
                        end else begin
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd1) begin
                        r_cnt        <= 4'd0;
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                        r_resp_rdata <= w_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_rdata  = r_resp_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_byte_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_byte_memory_ctrl
//   Three instances of byte_memory_ctrl (LATENCY 1, 4 and 3, DEPTH 64) run the
//   same directed + random sequence side by side. Each instance has its own
//   driver, a byte-array reference model and a monitor popping an expected
//   queue whenever resp_valid is seen.
// -----------------------------------------------------------------------------
module tb_byte_memory_ctrl;

    localparam int NI        = 3;
    localparam int LATS [NI] = '{1, 4, 3};
    localparam int MDEPTH    = 64;

    // ---------------- clock / reset / bookkeeping ----------------
    logic clk = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-latency instance ----------------
    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int L = LATS[gi];

        logic        rst_n;
        logic        req_valid;
        logic        req_ready;
        logic        req_write;
        logic [1:0]  req_size;
        logic        req_unsigned;
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        logic        resp_valid;
        logic        resp_err;
        logic [31:0] resp_rdata;
        logic [1:0]  dbg_state;

        bit          fin = 1'b0;
        int          last_acc = 0;
        logic [7:0]  m_mem [MDEPTH];
        logic [33:0] exp_q [$];   // {check_rdata, err, rdata}
        int          due_q [$];   // cycle index at which resp_valid is due
        logic [33:0] mon_e;
        int          mon_due;

        byte_memory_ctrl #(
            .DEPTH    (MDEPTH),
            .ADDR_W   (32),
            .LATENCY  (L),
            .INIT_FILE("")
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_valid   (req_valid),
            .req_ready   (req_ready),
            .req_write   (req_write),
            .req_size    (req_size),
            .req_unsigned(req_unsigned),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .resp_valid  (resp_valid),
            .resp_err    (resp_err),
            .resp_rdata  (resp_rdata),
            .o_dbg_state (dbg_state)
        );

        // Reference model: plain byte array, big-endian by construction.
        function automatic logic [33:0] model(input logic w, input logic [1:0] sz,
                                               input logic uns, input logic [31:0] a,
                                               input logic [31:0] d);
            int          nb;
            longint      last;
            logic [31:0] v;
            bit          err;
            nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            last = longint'({32'b0, a}) + longint'(nb) - 1;
            err  = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
                   (sz == 2'd2 && (a % 4) != 0) || (last >= MDEPTH);
            if (err) return {1'b1, 1'b1, 32'd0};
            if (w) begin
                for (int k = 0; k < nb; k++)
                    m_mem[int'(a) + k] = 8'((d >> (8 * (nb - 1 - k))) & 32'hFF);
                return {1'b0, 1'b0, 32'd0};
            end
            v = 32'd0;
            for (int k = 0; k < nb; k++) v = (v << 8) | 32'(m_mem[int'(a) + k]);
            if (!uns && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
            return {1'b1, 1'b0, v};
        endfunction

        task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] d,
                              input bit hold, input bit chk_period);
            int n;
            int acc;
            @(negedge clk);
            req_valid = 1'b1; req_write = w; req_size = sz;
            req_unsigned = uns; req_addr = a; req_wdata = d;
            n = 0;
            while (!req_ready && n < 100) begin @(negedge clk); n++; end
            if (!req_ready) begin
                check($sformatf("L%0d accept timeout", L), 32'(req_ready), 32'd1);
                req_valid = 1'b0;
                return;
            end
            acc = cyc + 1;
            if (chk_period) check($sformatf("L%0d accept spacing", L), 32'(acc - last_acc), 32'(L + 1));
            last_acc = acc;
            exp_q.push_back(model(w, sz, uns, a, d));
            due_q.push_back(acc + L - 1);
            @(posedge clk); #1;
            if (hold) begin
                // Keep valid high with junk that must be ignored while busy.
                req_write = 1'($urandom); req_size = 2'($urandom);
                req_unsigned = 1'($urandom); req_addr = $urandom_range(0, MDEPTH - 1);
                req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
        endtask

        task automatic drain();
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
            check($sformatf("L%0d pending responses", L), 32'(exp_q.size()), 32'd0);
        endtask

        task automatic check_idle_outputs(input string tag);
            check($sformatf("L%0d %s req_ready", L, tag), 32'(req_ready), 32'd1);
            check($sformatf("L%0d %s resp_valid", L, tag), 32'(resp_valid), 32'd0);
            check($sformatf("L%0d %s resp_err", L, tag), 32'(resp_err), 32'd0);
            check($sformatf("L%0d %s resp_rdata", L, tag), resp_rdata, 32'd0);
            check($sformatf("L%0d %s state", L, tag), 32'(dbg_state), 32'd0);
        endtask

        // Store accepted, then reset sampled low on its commit edge
        // (LATENCY-1 edges after acceptance): no response, no write.
        task automatic abort_store(input logic [31:0] a, input logic [31:0] d);
            int n;
            drain();
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
            req_unsigned = 1'b0; req_addr = a; req_wdata = d;
            n = 0;
            while (!req_ready && n < 100) begin @(negedge clk); n++; end
            for (int k = 0; k < L - 1; k++) begin @(negedge clk); req_valid = 1'b0; end
            rst_n = 1'b0;
            @(negedge clk);
            req_valid = 1'b0;
            rst_n = 1'b1;
            check_idle_outputs("after abort");
        endtask

        // Monitor / scoreboard
        always @(negedge clk) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("L%0d unexpected resp_valid", L), 32'(resp_valid), 32'd0);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_due = due_q.pop_front();
                    check($sformatf("L%0d resp cycle", L), 32'(cyc), 32'(mon_due));
                    check($sformatf("L%0d resp_err", L), 32'(resp_err), 32'(mon_e[32]));
                    if (mon_e[33]) check($sformatf("L%0d resp_rdata", L), resp_rdata, mon_e[31:0]);
                    check($sformatf("L%0d req_ready in RESP", L), 32'(req_ready), 32'd0);
                end
            end else if (resp_err) begin
                check($sformatf("L%0d resp_err outside RESP", L), 32'(resp_err), 32'd0);
            end
        end

        // Stimulus
        initial begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          r;
            rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
            req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
            @(negedge clk);
            check_idle_outputs("power-up reset");
            rst_n = 1'b1;

            // Fill the whole array so the model knows every byte.
            for (int i = 0; i < MDEPTH / 4; i++) do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b0, 1'b0);

            // Word store/load and sub-word loads, byte store merge
            do_req(1'b1, 2'd2, 1'b0, 32'd8,  32'h8899_AABB, 1'b0, 1'b0);
            do_req(1'b0, 2'd2, 1'b0, 32'd8,  32'd0,         1'b0, 1'b0);
            do_req(1'b0, 2'd0, 1'b0, 32'd8,  32'd0,         1'b0, 1'b0);
            do_req(1'b0, 2'd0, 1'b1, 32'd9,  32'd0,         1'b0, 1'b0);
            do_req(1'b0, 2'd1, 1'b0, 32'd10, 32'd0,         1'b0, 1'b0);
            do_req(1'b1, 2'd0, 1'b0, 32'd11, 32'h1234_5677, 1'b0, 1'b0);
            do_req(1'b0, 2'd2, 1'b0, 32'd8,  32'd0,         1'b0, 1'b0);

            // Error cases and range boundaries
            do_req(1'b0, 2'd2, 1'b0, 32'd6,  32'd0,         1'b0, 1'b0);
            do_req(1'b0, 2'd1, 1'b0, 32'd5,  32'd0,         1'b0, 1'b0);
            do_req(1'b0, 2'd3, 1'b0, 32'd0,  32'd0,         1'b0, 1'b0);
            do_req(1'b1, 2'd2, 1'b0, 32'd62, 32'hCAFE_F00D, 1'b0, 1'b0);
            do_req(1'b0, 2'd2, 1'b0, 32'd60, 32'd0,         1'b0, 1'b0);
            do_req(1'b0, 2'd0, 1'b0, 32'd63, 32'd0,         1'b0, 1'b0);
            do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'd0,  1'b0, 1'b0);
            do_req(1'b0, 2'd1, 1'b0, 32'd64, 32'd0,         1'b0, 1'b0);

            // Back-to-back with req_valid held high: accepts are L+1 apart
            do_req(1'b0, 2'd2, 1'b0, 32'd16, 32'd0, 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) do_req(1'b0, 2'd0, 1'($urandom), 32'($urandom_range(0, 63)), 32'd0, 1'b1, 1'b1);
            do_req(1'b0, 2'd2, 1'b0, 32'd20, 32'd0, 1'b0, 1'b1);

            // Reset during an in-flight store
            abort_store(32'd0, 32'hDEAD_BEEF);
            do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

            // Random traffic
            for (int i = 0; i < 150; i++) begin
                r  = $urandom_range(0, 9);
                sz = (r == 9) ? 2'd3 : 2'(r % 3);
                a  = $urandom_range(0, MDEPTH + 3);
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'd1) a[0] = 1'b0;
                    if (sz == 2'd2) a[1:0] = 2'b00;
                end
                do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0, 1'b0);
            end

            drain();
            fin = 1'b1;
        end
    end

    // ---------------- final report ----------------
    initial begin : main
        int t;
        logic [2:0] all_done;
        t = 0;
        all_done = 3'b000;
        while (all_done != 3'b111 && t < 40000) begin
            @(negedge clk);
            all_done = {g_inst[2].fin, g_inst[1].fin, g_inst[0].fin};
            t++;
        end
        if (all_done != 3'b111) check("run completion", 32'(all_done), 32'h7);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
